uart_tx_queue_ctrl: RTL

//  Buffers CPU bytes written to the UART data IO word in a small FIFO.

---
 rtl/uart_tx_queue_ctrl_if.sv | 26 ++
 rtl/uart_tx_queue_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/uart_tx_queue_ctrl_if.sv
// CPU-side and txuart-side signals of the UART transmit queue.
// The slave modport is the queue controller; the master modport is the CPU decode / txuart side.
interface uart_tx_queue_ctrl_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  wr_i;
  logic [7:0]            wdata_i;
  logic                  cpu_busy_o;
  logic                  empty_o;
  logic [DEPTH_LOG2:0]   level_o;
  logic                  uart_wr_o;
  logic [7:0]            uart_data_o;
  logic                  uart_busy_i;
  logic                  clr_ovf_i;
  logic                  ovf_o;

  modport master (
    output wr_i, wdata_i, clr_ovf_i, uart_busy_i,
    input  cpu_busy_o, empty_o, level_o, uart_wr_o, uart_data_o, ovf_o
  );

  modport slave (
    input  wr_i, wdata_i, clr_ovf_i, uart_busy_i,
    output cpu_busy_o, empty_o, level_o, uart_wr_o, uart_data_o, ovf_o
  );
endinterface

// File: rtl/uart_tx_queue_ctrl.sv
// UART transmit queue: FIFO of CPU bytes handed one at a time to txuart via i_wr/o_busy.
// Optional sticky overflow flag enabled by defining UART_TXQ_OVF_EN.
module uart_tx_queue_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned BUSY_WAIT  = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  uart_tx_queue_ctrl_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned WW    = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [WW-1:0]          wait_q, wait_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]          count_q, count_d;
  logic [7:0]             mem [DEPTH];
  logic                   push, pop;

  // A write seen while full is dropped even if a pop happens on the same edge.
  assign push = bus.wr_i && !bus.cpu_busy_o;

  // Next state; the pop into the output holding register happens on IDLE->ISSUE.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((count_q != '0) && !bus.uart_busy_i) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        // txuart busy may lag i_wr; give up waiting after BUSY_WAIT cycles.
        if (bus.uart_busy_i || (wait_q == WW'(BUSY_WAIT - 1))) begin
          state_d = WAIT_DONE;
        end else begin
          wait_d = WW'(wait_q + WW'(1));
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = CW'(count_q + CW'(1));
      2'b01:   count_d = CW'(count_q - CW'(1));
      default: count_d = count_q;
    endcase
  end

  // State, pointers and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      wait_q          <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count_q         <= '0;
      bus.uart_wr_o   <= 1'b0;
      bus.uart_data_o <= 8'h00;
      bus.cpu_busy_o  <= 1'b0;
      bus.empty_o     <= 1'b1;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      count_q        <= count_d;
      bus.uart_wr_o  <= (state_d == ISSUE);
      bus.cpu_busy_o <= (count_d == CW'(DEPTH));
      bus.empty_o    <= (count_d == '0) && (state_d == IDLE);
      if (push) wr_ptr <= DEPTH_LOG2'(wr_ptr + DEPTH_LOG2'(1));
      if (pop) begin
        bus.uart_data_o <= mem[rd_ptr];
        rd_ptr          <= DEPTH_LOG2'(rd_ptr + DEPTH_LOG2'(1));
      end
    end
  end

  // Storage has no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (!reset_i && push) mem[wr_ptr] <= bus.wdata_i;
  end

  assign bus.level_o = count_q;

`ifdef UART_TXQ_OVF_EN
  // Sticky overflow: set on a dropped write, set wins over clear.
  logic ovf_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_i && bus.cpu_busy_o) begin
      ovf_q <= 1'b1;
    end else if (bus.clr_ovf_i) begin
      ovf_q <= 1'b0;
    end
  end
  assign bus.ovf_o = ovf_q;
`else
  logic clr_ovf_unused;
  assign clr_ovf_unused = bus.clr_ovf_i;
  assign bus.ovf_o      = 1'b0;
`endif

endmodule
